// File: rtl/debouncer_bank.sv
// Bank of independent debouncers: per-channel 2-flop synchroniser, stability counter and rise/fall pulses.
// Define DEBOUNCER_BANK_REPEAT_EN to add the auto-repeat pulse generator on held-high channels.
module debouncer_bank #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 8,
  parameter int STABLE     = 255,
  parameter int RPT_W      = 16,
  parameter int RPT_FIRST  = 1000,
  parameter int RPT_PERIOD = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rep
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic             s0_reg;
    logic             s1_reg;
    logic             out_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             stable;
    logic             update;
    logic             out_next;

    assign stable   = (cnt_reg == STABLE_C);
    assign update   = stable && (s1_reg != out_reg);
    assign out_next = update ? s1_reg : out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0_reg   <= 1'b0;
        s1_reg   <= 1'b0;
        cnt_reg  <= '0;
        out_reg  <= 1'b0;
        rise_reg <= 1'b0;
        fall_reg <= 1'b0;
      end else begin
        s0_reg <= in[gi];
        s1_reg <= s0_reg;
        // Any difference between the two sync stages restarts the stability window.
        if (s0_reg != s1_reg) begin
          cnt_reg <= '0;
        end else if (!stable) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        out_reg  <= out_next;
        rise_reg <= update && s1_reg;
        fall_reg <= update && !s1_reg;
      end
    end

    assign out[gi]  = out_reg;
    assign rise[gi] = rise_reg;
    assign fall[gi] = fall_reg;

`ifdef DEBOUNCER_BANK_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_MAX   = {RPT_W{1'b1}};
    localparam logic [RPT_W:0]   FIRST_C   = (RPT_W+1)'(RPT_FIRST);
    localparam logic [RPT_W+1:0] PERIOD_C  = (RPT_W+2)'(RPT_PERIOD);
    // One past the largest count value: a due point here can never be reached.
    localparam logic [RPT_W+1:0] DUE_LIMIT = {2'b01, {RPT_W{1'b0}}};

    logic [RPT_W-1:0] rpt_cnt_reg;
    logic [RPT_W:0]   rpt_due_reg;
    logic             rep_reg;
    logic             rpt_hit;
    logic [RPT_W+1:0] due_sum;
    logic [RPT_W:0]   due_next;

    assign rpt_hit  = out_reg && ({1'b0, rpt_cnt_reg} == rpt_due_reg);
    assign due_sum  = {1'b0, rpt_due_reg} + PERIOD_C;
    assign due_next = (due_sum > DUE_LIMIT) ? DUE_LIMIT[RPT_W:0] : due_sum[RPT_W:0];

    // rpt_cnt_reg counts cycles with out high; rpt_due_reg is the count of the next repeat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rpt_cnt_reg <= '0;
        rpt_due_reg <= FIRST_C;
        rep_reg     <= 1'b0;
      end else if (!out_next) begin
        rpt_cnt_reg <= '0;
        rpt_due_reg <= FIRST_C;
        rep_reg     <= 1'b0;
      end else begin
        if (rpt_cnt_reg != RPT_MAX) begin
          rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
        end
        if (rpt_hit) begin
          rpt_due_reg <= due_next;
        end
        rep_reg <= rpt_hit;
      end
    end

    assign rep[gi] = rep_reg;
`else
    assign rep[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank: expected outputs are queued per cycle and checked after each edge.
module tb_debouncer_bank;

  localparam int STABLE     = 3;
  localparam int RPT_FIRST  = 5;
  localparam int RPT_PERIOD = 2;
`ifdef DEBOUNCER_BANK_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rep;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic [3:0] out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] rep;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc_no = 0;
  string cur_tag = "idle";

  debouncer_bank #(
    .CHANNELS  (4),
    .CNT_W     (8),
    .STABLE    (STABLE),
    .RPT_W     (8),
    .RPT_FIRST (RPT_FIRST),
    .RPT_PERIOD(RPT_PERIOD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .out  (out),
    .rise (rise),
    .fall (fall),
    .rep  (rep)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: one queued expectation per clock edge.
  always @(posedge clk) begin : sb
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cyc_no++;
      check($sformatf("%s t%0d out", cur_tag, cyc_no), out, e.out);
      check($sformatf("%s t%0d rise", cur_tag, cyc_no), rise, e.rise);
      check($sformatf("%s t%0d fall", cur_tag, cyc_no), fall, e.fall);
      check($sformatf("%s t%0d rep", cur_tag, cyc_no), rep, e.rep);
      $display("%s t%0d in=%b out=%b rise=%b fall=%b rep=%b", cur_tag, cyc_no, in, out, rise, fall, rep);
    end
  end

  task automatic tick(input logic [3:0] v, input exp_t e);
    @(negedge clk);
    in = v;
    exp_q.push_back(e);
  endtask

  // Channels in mask follow pat on ticks 1..3, then stay 1 until tick rel where they drop to 0.
  // r is the tick of the expected rise; the fall lands STABLE+2 ticks after rel.
  task automatic scenario(input string name, input logic [3:0] mask, input logic [2:0] pat,
                          input int rel, input int r, input int len);
    cur_tag = name;
    cyc_no  = 0;
    for (int t = 1; t <= len; t++) begin
      logic b;
      exp_t e;
      int   f;
      f      = rel + STABLE + 2;
      b      = (t <= 3) ? pat[t-1] : (t < rel);
      e.out  = (t >= r && t < f) ? mask : 4'b0000;
      e.rise = (t == r) ? mask : 4'b0000;
      e.fall = (t == f) ? mask : 4'b0000;
      e.rep  = (REP_EN && t >= r + RPT_FIRST && t < f &&
                ((t - r - RPT_FIRST) % RPT_PERIOD) == 0) ? mask : 4'b0000;
      tick(b ? mask : 4'b0000, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in    = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset out", out, 4'b0000);
    check("reset rise", rise, 4'b0000);
    check("reset fall", fall, 4'b0000);
    check("reset rep", rep, 4'b0000);
    rst_n = 1'b1;

    scenario("idle", 4'b0000, 3'b000, 0, 1000, 8);
    scenario("ch0_rise", 4'b0001, 3'b111, 16, 6, 24);
    scenario("ch1_bounce", 4'b0010, 3'b101, 11, 8, 20);
    scenario("ch2_repeat", 4'b0100, 3'b111, 19, 6, 28);
    scenario("all_rise", 4'b1111, 3'b111, 1000, 6, 8);

    // Asynchronous reset while all outputs are high: must clear at once with no fall pulse.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out", out, 4'b0000);
    check("midrst rise", rise, 4'b0000);
    check("midrst fall", fall, 4'b0000);
    check("midrst rep", rep, 4'b0000);
    repeat (2) begin
      @(posedge clk);
      #2;
      check("inrst out", out, 4'b0000);
      check("inrst fall", fall, 4'b0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // The edge right after release is the first edge seeing in=1111, so the rise lands on tick 5.
    scenario("post_rst", 4'b1111, 3'b111, 1000, 5, 8);

    @(posedge clk);
    #3;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
